// File: rtl/const_load_gen.sv
// Encodes a 64-bit constant back into a LEGv8 immediate field (I/D/B/CB),
// or into a MOVZ/MOVK word sequence that loads it into Rd (IW).
module const_load_gen #(
  parameter logic [8:0] MOVZ_OPC = 9'b110100101,
  parameter logic [8:0] MOVK_OPC = 9'b111100101
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_imm,
  input  logic [2:0]  in_ctrl,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic        out_last,
  output logic        out_err
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [2:0] CTRL_I  = 3'b000;
  localparam logic [2:0] CTRL_D  = 3'b001;
  localparam logic [2:0] CTRL_B  = 3'b010;
  localparam logic [2:0] CTRL_CB = 3'b011;
  localparam logic [2:0] CTRL_IW = 3'b100;

  state_t      state_q, state_d;
  logic [63:0] imm_q, imm_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] ins_q, ins_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic [3:0]  nz;
  logic [1:0]  first_k, next_k;
  logic [31:0] first_ins;
  logic        first_last, first_err;
  logic [3:0]  first_mask;

  // True when v, read as signed, survives truncation to w bits unchanged.
  function automatic logic fits_signed(input logic [63:0] v, input int unsigned w);
    logic signed [63:0] s;
    s = $signed(v) >>> (w - 1);
    return (s == '0) || (s == '1);
  endfunction

  // An empty mask maps to quarter 0 so imm==0 still yields MOVZ #0.
  function automatic logic [1:0] lowest_k(input logic [3:0] m);
    casez (m)
      4'b???1: return 2'd0;
      4'b??10: return 2'd1;
      4'b?100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] iw_word(input logic [8:0] opc, input logic [1:0] k,
                                          input logic [15:0] q, input logic [4:0] rd);
    return {opc, k, q, rd};
  endfunction

  // First word of a request, computed straight from the inputs.
  always_comb begin
    for (int k = 0; k < 4; k++) nz[k] = |in_imm[16*k +: 16];
    first_k    = lowest_k(nz);
    first_ins  = '0;
    first_last = 1'b1;
    first_err  = 1'b0;
    first_mask = '0;
    case (in_ctrl)
      CTRL_I: begin
        first_ins = {10'b0, in_imm[11:0], 5'b0, in_rd};
        first_err = !fits_signed(in_imm, 12);
      end
      CTRL_D: begin
        first_ins = {11'b0, in_imm[8:0], 7'b0, in_rd};
        first_err = !fits_signed(in_imm, 9);
      end
      CTRL_B: begin
        first_ins = {6'b0, in_imm[25:0]};
        first_err = !fits_signed(in_imm, 26);
      end
      CTRL_CB: begin
        first_ins = {8'b0, in_imm[18:0], in_rd};
        first_err = !fits_signed(in_imm, 19);
      end
      CTRL_IW: begin
        first_ins  = iw_word(MOVZ_OPC, first_k, in_imm[{first_k, 4'b0} +: 16], in_rd);
        first_mask = nz & ~(4'b0001 << first_k);
        first_last = (first_mask == 4'b0);
      end
      default: first_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    mask_d  = mask_q;
    ins_d   = ins_q;
    last_d  = last_q;
    err_d   = err_q;
    next_k  = lowest_k(mask_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          imm_d   = in_imm;
          rd_d    = in_rd;
          mask_d  = first_mask;
          ins_d   = first_ins;
          last_d  = first_last;
          err_d   = first_err;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            // Only IW requests have follow-on words: next pending quarter as MOVK.
            ins_d  = iw_word(MOVK_OPC, next_k, imm_q[{next_k, 4'b0} +: 16], rd_q);
            mask_d = mask_q & ~(4'b0001 << next_k);
            last_d = (mask_d == 4'b0);
            err_d  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      imm_q   <= '0;
      rd_q    <= '0;
      mask_q  <= '0;
      ins_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      mask_q  <= mask_d;
      ins_q   <= ins_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_ins   = ins_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_const_load_gen.sv
// Bench for const_load_gen: directed vectors plus randomized requests with
// random backpressure checked against an arithmetic reference model.
module tb_const_load_gen;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_imm = '0;
  logic [2:0]  in_ctrl = '0;
  logic [4:0]  in_rd = '0;
  logic        in_ready, out_valid, out_last, out_err;
  logic [31:0] out_ins;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_ins[$];
  logic        exp_last[$];
  logic        exp_err[$];

  const_load_gen dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_ctrl(in_ctrl), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ins(out_ins), .out_last(out_last), .out_err(out_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Drives one request starting at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [63:0] imm, input logic [2:0] ctrl, input logic [4:0] rd,
                       output bit ok);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    ok = in_ready;
    if (ok) begin
      in_valid = 1'b1; in_imm = imm; in_ctrl = ctrl; in_rd = rd;
      @(negedge CLK);
      in_valid = 1'b0;
      in_imm = {$urandom, $urandom}; in_ctrl = 3'($urandom); in_rd = 5'($urandom);
    end
  endtask

  function automatic bit in_range(input logic [63:0] imm, input int w);
    longint s = longint'(imm);
    longint lim = longint'(1) << (w - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  // Reference: expected word list derived from the format rules with plain arithmetic.
  task automatic model(input logic [63:0] imm, input logic [2:0] ctrl, input logic [4:0] rd);
    int ks[$];
    logic [31:0] w;
    exp_ins.delete(); exp_last.delete(); exp_err.delete();
    case (ctrl)
      3'd0: begin exp_ins.push_back(32'((imm & 64'hFFF) << 10) | 32'(rd));
                  exp_err.push_back(!in_range(imm, 12)); exp_last.push_back(1'b1); end
      3'd1: begin exp_ins.push_back(32'((imm & 64'h1FF) << 12) | 32'(rd));
                  exp_err.push_back(!in_range(imm, 9)); exp_last.push_back(1'b1); end
      3'd2: begin exp_ins.push_back(32'(imm & 64'h3FF_FFFF));
                  exp_err.push_back(!in_range(imm, 26)); exp_last.push_back(1'b1); end
      3'd3: begin exp_ins.push_back(32'((imm & 64'h7FFFF) << 5) | 32'(rd));
                  exp_err.push_back(!in_range(imm, 19)); exp_last.push_back(1'b1); end
      3'd4: begin
        for (int k = 0; k < 4; k++)
          if (((imm >> (16 * k)) & 64'hFFFF) != 0) ks.push_back(k);
        if (ks.size() == 0) ks.push_back(0);
        for (int i = 0; i < ks.size(); i++) begin
          w = (32'((i == 0) ? 9'h1A5 : 9'h1E5) << 23) | (32'(ks[i]) << 21)
            | (32'((imm >> (16 * ks[i])) & 64'hFFFF) << 5) | 32'(rd);
          exp_ins.push_back(w);
          exp_last.push_back(i == ks.size() - 1);
          exp_err.push_back(1'b0);
        end
      end
      default: begin exp_ins.push_back(32'h0); exp_err.push_back(1'b1); exp_last.push_back(1'b1); end
    endcase
  endtask

  task automatic test_reset();
    Reset_L = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0 || out_ins !== 32'h0 || out_last !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b ins=%h last=%b err=%b, expected v=0 ins=00000000 last=0 err=0",
               out_valid, out_ins, out_last, out_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    Reset_L = 1'b1;
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_iw_two();
    bit ok;
    out_ready = 1'b1;
    issue(64'h0000_1234_0000_5678, 3'b100, 5'd3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL iw_two_accept: in_ready=0 expected 1"); return; end
    checks++;
    if (out_valid !== 1'b1 || out_ins !== 32'hD28ACF03 || out_last !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL iw_two_w0: got v=%b ins=%h last=%b err=%b, expected v=1 ins=d28acf03 last=0 err=0",
               out_valid, out_ins, out_last, out_err);
    end
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b1 || out_ins !== 32'hF2C24683 || out_last !== 1'b1 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL iw_two_w1: got v=%b ins=%h last=%b err=%b, expected v=1 ins=f2c24683 last=1 err=0",
               out_valid, out_ins, out_last, out_err);
    end
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL iw_two_idle: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_iw_zero();
    bit ok;
    out_ready = 1'b1;
    issue(64'h0, 3'b100, 5'd0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL iw_zero_accept: in_ready=0 expected 1"); return; end
    checks++;
    if (out_valid !== 1'b1 || out_ins !== 32'hD2800000 || out_last !== 1'b1 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL iw_zero: got v=%b ins=%h last=%b err=%b, expected v=1 ins=d2800000 last=1 err=0",
               out_valid, out_ins, out_last, out_err);
    end
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL iw_zero_idle: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_iw_ones_backpressure();
    logic [31:0] w[4] = '{32'hD29FFFFF, 32'hF2BFFFFF, 32'hF2DFFFFF, 32'hF2FFFFFF};
    bit ok;
    out_ready = 1'b1;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 5'd31, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ones_accept: in_ready=0 expected 1"); return; end
    checks++;
    if (out_valid !== 1'b1 || out_ins !== w[0] || out_last !== 1'b0) begin
      errors++; $display("FAIL ones_w0: got v=%b ins=%h last=%b expected v=1 ins=%h last=0",
                         out_valid, out_ins, out_last, w[0]);
    end
    @(negedge CLK);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_ins !== w[1] || out_last !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ones_stall%0d: got v=%b ins=%h last=%b rdy=%b expected v=1 ins=%h last=0 rdy=0",
                 c, out_valid, out_ins, out_last, in_ready, w[1]);
      end
      if (c < 5) @(negedge CLK);
    end
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b1 || out_ins !== w[i] || out_last !== (i == 3) || out_err !== 1'b0) begin
        errors++;
        $display("FAIL ones_w%0d: got v=%b ins=%h last=%b err=%b expected v=1 ins=%h last=%b err=0",
                 i, out_valid, out_ins, out_last, out_err, w[i], (i == 3));
      end
    end
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ones_idle: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_formats();
    logic [63:0] imm[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2048, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,
                            64'hFFFF_FFFF_FFFF_FF00, 64'd256, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [2:0]  ctl[7] = '{3'b000, 3'b000, 3'b010, 3'b111, 3'b001, 3'b001, 3'b011};
    logic [4:0]  rd[7]  = '{5'd5, 5'd0, 5'd7, 5'd9, 5'd1, 5'd0, 5'd2};
    logic [31:0] ins[7] = '{32'h003FFC05, 32'h00200000, 32'h03FFFFFC, 32'h0,
                            32'h00100001, 32'h00100000, 32'h00FFFFE2};
    logic        err[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      issue(imm[i], ctl[i], rd[i], ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL fmt%0d_accept: in_ready=0 expected 1", i); continue; end
      checks++;
      if (out_valid !== 1'b1 || out_ins !== ins[i] || out_last !== 1'b1 || out_err !== err[i]) begin
        errors++;
        $display("FAIL fmt%0d: got v=%b ins=%h last=%b err=%b expected v=1 ins=%h last=1 err=%b",
                 i, out_valid, out_ins, out_last, out_err, ins[i], err[i]);
      end
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL fmt%0d_idle: got v=%b rdy=%b expected v=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_midseq();
    bit ok;
    out_ready = 1'b1;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 5'd31, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_accept: in_ready=0 expected 1"); return; end
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b1 || out_ins !== 32'hF2BFFFFF) begin
      errors++; $display("FAIL rstmid_w1: got v=%b ins=%h expected v=1 ins=f2bfffff", out_valid, out_ins);
    end
    #2 Reset_L = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ins !== 32'h0 || out_last !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: got v=%b ins=%h last=%b err=%b expected v=0 ins=00000000 last=0 err=0",
               out_valid, out_ins, out_last, out_err);
    end
    @(negedge CLK);
    Reset_L = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL rstmid_quiet%0d: got v=%b rdy=%b expected v=0 rdy=1", c, out_valid, in_ready);
      end
    end
    issue(64'h5678, 3'b100, 5'd3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_new_accept: in_ready=0 expected 1"); return; end
    checks++;
    if (out_valid !== 1'b1 || out_ins !== 32'hD28ACF03 || out_last !== 1'b1) begin
      errors++; $display("FAIL rstmid_new: got v=%b ins=%h last=%b expected v=1 ins=d28acf03 last=1",
                         out_valid, out_ins, out_last);
    end
    @(negedge CLK);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_new_idle: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_random();
    longint edges[16] = '{2047, 2048, -2048, -2049, 255, 256, -256, -257,
                          (1 << 25) - 1, 1 << 25, -(1 << 25), -(1 << 25) - 1,
                          (1 << 18) - 1, 1 << 18, -(1 << 18), -(1 << 18) - 1};
    logic [63:0] imm;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    bit ok;
    int idx, cyc;
    out_ready = 1'b0;
    for (int r = 0; r < 60; r++) begin
      ctrl = ($urandom_range(1) == 1) ? 3'd4 : 3'($urandom_range(7));
      rd = 5'($urandom);
      case ($urandom_range(3))
        0: imm = {$urandom, $urandom};
        1: begin imm = {$urandom, $urandom}; imm = 64'($signed(imm) >>> $urandom_range(36, 56)); end
        2: begin
          imm = {$urandom, $urandom};
          for (int k = 0; k < 4; k++) if ($urandom_range(1) == 1) imm[16*k +: 16] = '0;
        end
        default: imm = 64'(edges[$urandom_range(15)]);
      endcase
      model(imm, ctrl, rd);
      issue(imm, ctrl, rd, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand%0d_accept: in_ready=0 expected 1", r); continue; end
      idx = 0; cyc = 0;
      while (idx < exp_ins.size() && cyc < 100) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL rand%0d_valid word %0d: got v=%b expected 1", r, idx, out_valid);
          break;
        end
        checks++;
        if (out_ins !== exp_ins[idx] || out_last !== exp_last[idx] || out_err !== exp_err[idx]
            || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL rand%0d_word%0d imm=%h ctrl=%0d: got ins=%h last=%b err=%b rdy=%b expected ins=%h last=%b err=%b rdy=0",
                   r, idx, imm, ctrl, out_ins, out_last, out_err, in_ready,
                   exp_ins[idx], exp_last[idx], exp_err[idx]);
        end
        out_ready = ($urandom_range(99) >= 30);
        if (out_ready) idx++;
        @(negedge CLK);
        cyc++;
      end
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL rand%0d_done: got v=%b rdy=%b expected v=0 rdy=1", r, out_valid, in_ready);
        Reset_L = 1'b0; @(negedge CLK); Reset_L = 1'b1; @(negedge CLK);
      end
    end
  endtask

  initial begin
    test_reset();
    test_iw_two();
    test_iw_zero();
    test_iw_ones_backpressure();
    test_formats();
    test_reset_midseq();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
